// File: rtl/button_pkg.sv
// Shared constants and helpers for the pmod pushbutton debouncer.
package button_pkg;

    localparam int CLK_HZ                  = 12000000;
    localparam int DEBOUNCE_MS_DEFAULT     = 10;
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

    // Counter width that can hold n-1 and is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounced button: 2-flop synchronizer (inverting), stability counter, level and pulses.
// The release pulse output exists only when BUTTON_DEBOUNCER_RELEASE_EN is defined.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_n,
    output logic level,
    output logic press
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    ,
    output logic release_pulse
`endif
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    deb_state_e       state;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    logic             release_q, release_d;
`endif

    // State is implied by whether the synchronized input disagrees with the accepted level.
    always_comb begin
        s1_d    = ~pin_n;
        s2_d    = s1_q;
        state   = (s2_q != level_q) ? COUNTING : IDLE;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        release_d = 1'b0;
`endif
        if (state == COUNTING) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
                press_d = s2_q;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
                release_d = ~s2_q;
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            release_q <= 1'b0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            release_q <= release_d;
`endif
        end
    end

    assign level = level_q;
    assign press = press_q;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    assign release_pulse = release_q;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTNS active-low pmod buttons into active-high levels and press pulses.
// Define BUTTON_DEBOUNCER_RELEASE_EN to add the btn_release pulse outputs.
module button_debouncer
    import button_pkg::*;
#(
    parameter int NUM_BTNS        = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] pmod,
    output logic [NUM_BTNS-1:0] btn,
    output logic [NUM_BTNS-1:0] btn_press
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    ,
    output logic [NUM_BTNS-1:0] btn_release
`endif
);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .pin_n        (pmod[i]),
            .level        (btn[i]),
            .press        (btn_press[i])
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            ,
            .release_pulse(btn_release[i])
`endif
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES = 8 and three buttons.
module tb_button_debouncer;

    localparam int N  = 8;
    localparam int NB = 3;
    localparam int HL = N + 2;

    typedef struct {
        logic [NB-1:0] pmod;
        int            hold;
        logic [NB-1:0] exp_btn;
    } vec_t;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic [NB-1:0] pmod = '1;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_press;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    logic [NB-1:0] btn_release;
`endif

    int checks = 0;
    int errors = 0;
    bit sb_en  = 1'b0;

    logic [HL-1:0] hist [NB];
    logic [NB-1:0] btn_m, press_m, rel_m;
    vec_t          vecs [8];

    always #5 clk = ~clk;

    button_debouncer #(
        .NUM_BTNS       (NB),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pmod       (pmod),
        .btn        (btn),
        .btn_press  (btn_press)
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        ,
        .btn_release(btn_release)
`endif
    );

    // Reference: a level is accepted once the last N synchronized samples all agree and differ from it.
    always @(posedge clk) begin : model
        logic [N-1:0] win;
        for (int c = 0; c < NB; c++) begin
            if (rst) begin
                hist[c]    = '0;
                btn_m[c]   = 1'b0;
                press_m[c] = 1'b0;
                rel_m[c]   = 1'b0;
            end else begin
                win        = hist[c][N:1];
                press_m[c] = 1'b0;
                rel_m[c]   = 1'b0;
                if (win == '1 && !btn_m[c]) begin
                    btn_m[c]   = 1'b1;
                    press_m[c] = 1'b1;
                end else if (win == '0 && btn_m[c]) begin
                    btn_m[c] = 1'b0;
                    rel_m[c] = 1'b1;
                end
                hist[c] = {hist[c][HL-2:0], ~pmod[c]};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] p);
        pmod = p;
    endtask

    task automatic stepTo(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_en) begin
            checkOutput("sb_btn", btn, btn_m);
            checkOutput("sb_press", btn_press, press_m);
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            checkOutput("sb_release", btn_release, rel_m);
`endif
        end
    end

    initial begin
        vecs[0] = '{3'b110, 12, 3'b001};
        vecs[1] = '{3'b100, 12, 3'b011};
        vecs[2] = '{3'b000, 12, 3'b111};
        vecs[3] = '{3'b011, 5,  3'b111};
        vecs[4] = '{3'b000, 12, 3'b111};
        vecs[5] = '{3'b111, 12, 3'b000};
        vecs[6] = '{3'b010, 12, 3'b101};
        vecs[7] = '{3'b111, 12, 3'b000};

        rst = 1'b1;
        applyStimulus(3'b111);
        stepTo(2);
        rst   = 1'b0;
        sb_en = 1'b1;

        for (int i = 0; i < 20; i++) begin
            stepTo(1);
            checkOutput("rst_btn", btn, 3'b000);
            checkOutput("rst_press", btn_press, 3'b000);
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            checkOutput("rst_release", btn_release, 3'b000);
`endif
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].pmod);
            stepTo(vecs[i].hold);
            checkOutput($sformatf("vec%0d_btn", i), btn, vecs[i].exp_btn);
        end

        $display("[TB] clean press");
        applyStimulus(3'b110);
        stepTo(9);
        checkOutput("press_early", btn, 3'b000);
        stepTo(1);
        checkOutput("press_btn", btn, 3'b001);
        checkOutput("press_pulse", btn_press, 3'b001);
        stepTo(1);
        checkOutput("press_pulse_end", btn_press, 3'b000);
        checkOutput("press_hold", btn, 3'b001);
        applyStimulus(3'b111);
        stepTo(12);

        $display("[TB] bounce");
        for (int seg = 0; seg < 10; seg++) begin
            applyStimulus((seg % 2 == 0) ? 3'b101 : 3'b111);
            for (int j = 0; j < 3; j++) begin
                stepTo(1);
                checkOutput("bounce_btn", btn, 3'b000);
            end
        end
        applyStimulus(3'b101);
        stepTo(9);
        checkOutput("bounce_early", btn, 3'b000);
        stepTo(1);
        checkOutput("bounce_btn_rise", btn, 3'b010);
        checkOutput("bounce_press", btn_press, 3'b010);
        applyStimulus(3'b111);
        stepTo(12);

        $display("[TB] simultaneous");
        applyStimulus(3'b000);
        stepTo(9);
        checkOutput("simul_early", btn, 3'b000);
        stepTo(1);
        checkOutput("simul_btn", btn, 3'b111);
        checkOutput("simul_press", btn_press, 3'b111);
        stepTo(1);
        checkOutput("simul_press_end", btn_press, 3'b000);
        applyStimulus(3'b111);
        stepTo(9);
        checkOutput("simul_rel_early", btn, 3'b111);
        stepTo(1);
        checkOutput("simul_rel_btn", btn, 3'b000);
        checkOutput("simul_rel_nopress", btn_press, 3'b000);
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        checkOutput("simul_release", btn_release, 3'b111);
`endif
        stepTo(2);

        $display("[TB] release");
        applyStimulus(3'b011);
        stepTo(12);
        checkOutput("rel_pressed", btn, 3'b100);
        applyStimulus(3'b111);
        stepTo(9);
        checkOutput("rel_early", btn, 3'b100);
        stepTo(1);
        checkOutput("rel_btn", btn, 3'b000);
        checkOutput("rel_nopress", btn_press, 3'b000);
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        checkOutput("rel_pulse", btn_release, 3'b100);
        stepTo(1);
        checkOutput("rel_pulse_end", btn_release, 3'b000);
`endif
        stepTo(2);

        $display("[TB] reset mid-count");
        applyStimulus(3'b110);
        stepTo(6);
        checkOutput("midrst_counting", btn, 3'b000);
        rst = 1'b1;
        stepTo(2);
        checkOutput("midrst_btn", btn, 3'b000);
        rst = 1'b0;
        stepTo(9);
        checkOutput("midrst_early", btn, 3'b000);
        stepTo(1);
        checkOutput("midrst_btn_rise", btn, 3'b001);
        checkOutput("midrst_press", btn_press, 3'b001);
        applyStimulus(3'b111);
        stepTo(12);
        checkOutput("pre_random_btn", btn, 3'b000);

        $display("[TB] random");
        for (int s = 0; s < 200; s++) begin
            applyStimulus(NB'($urandom_range(0, 7)));
            stepTo($urandom_range(1, 14));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
